// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 UART receiver with a first-word fall-through byte FIFO.
// Decodes the serial stream on ser_rx, buffers bytes, and raises sticky
// framing-error and overflow flags.
module uart_rx_monitor #(
    parameter int unsigned CLKS_PER_BIT = 4167,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned ADDR_W       = 3
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              ser_rx,
    input  logic              rx_ready,
    input  logic              clear_err,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    output logic [ADDR_W:0]   fifo_count,
    output logic              busy,
    output logic              frame_err,
    output logic              overflow
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_W:0] FullCount = ADDR_W'(FIFO_DEPTH) == '0 ?
                                            {1'b1, {ADDR_W{1'b0}}} : (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // Input synchronizer and edge-detect history
    logic sync1_q, rx_s_q, rx_prev_q;

    // Receive FSM state
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_q, push_d;
    logic            frame_set;

    // FIFO state
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              full, pop, push_ok, ovf_set;

    // Sticky flags
    logic frame_err_q, frame_err_d;
    logic overflow_q, overflow_d;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= ser_rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Frame decoder next-state: start qualification, data sampling, stop check
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        frame_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Only a true falling edge starts a frame, so a held break is ignored
                if (!rx_s_q && rx_prev_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d = StData;
                        idx_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    shift_d[idx_q] = rx_s_q;
                    cnt_d          = '0;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (rx_s_q) begin
                        push_d = 1'b1;
                    end else begin
                        frame_set = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO bookkeeping: pointers, occupancy, registered head, overflow detection
    always_comb begin
        full    = (count_q == FullCount);
        pop     = (count_q != '0) && rx_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle
        push_ok = push_q && (!full || pop);
        ovf_set = push_q && full && !pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + (ADDR_W + 1)'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - (ADDR_W + 1)'(1);
        end

        // Head register tracks the next head; the byte being written is bypassed
        rx_data_d = rx_data_q;
        if (count_d != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                rx_data_d = shift_q;
            end else begin
                rx_data_d = mem_q[rd_ptr_d];
            end
        end

        // A new error event outranks a simultaneous clear
        frame_err_d = frame_set | (frame_err_q & ~clear_err);
        overflow_d  = ovf_set | (overflow_q & ~clear_err);
    end

    // Receive FSM and FIFO control registers
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rx_data_q   <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rx_data_q   <= rx_data_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO storage; contents are only read once written, so no reset is needed
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = (count_q != '0);
    assign fifo_count = count_q;
    assign busy       = (state_q != StIdle);
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule
